// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode/sequencer: word geometry, opcode map,
// opcode classes and sequencer FSM states.
package isa_pkg;

    localparam int WORD_W = 20;
    localparam int REG_AW = 4;
    localparam int OPC_W  = 5;

    // Only the flow opcodes and the first code of each range are named;
    // the remaining codes are identified by their range.
    typedef enum logic [OPC_W-1:0] {
        OP_TRAP     = 5'h00,
        OP_NOP      = 5'h01,
        OP_JMP      = 5'h02,
        OP_JMPZ     = 5'h03,
        OP_JMPS     = 5'h04,
        OP_JMPZS    = 5'h05,
        OP_STATUS_LO = 5'h06,
        OP_LOGIC_LO = 5'h08,
        OP_SHIFT_LO = 5'h0C,
        OP_ARITH_LO = 5'h11,
        OP_CMP_LO   = 5'h17,
        OP_ILLEGAL_LO = 5'h1C
    } opcode_e;

    typedef enum logic [2:0] {
        CLS_FLOW,
        CLS_STATUS,
        CLS_LOGIC,
        CLS_SHIFT,
        CLS_ARITH,
        CLS_CMP,
        CLS_ILLEGAL
    } opclass_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_TARGET,
        ST_ISSUE,
        ST_WAIT,
        ST_TRAP
    } state_e;

    function automatic logic jump_taken(input logic [OPC_W-1:0] op,
                                        input logic zero,
                                        input logic sign);
        logic taken;
        taken = 1'b0;
        case (op)
            OP_JMP:   taken = 1'b1;
            OP_JMPZ:  taken = zero;
            OP_JMPS:  taken = sign;
            OP_JMPZS: taken = zero && sign;
            default:  taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/decode_seq_if.sv
// Bus bundle between the sequencer and its instruction memory, ALU and flags.
// The sequencer uses the master modport; the environment uses slave.
interface decode_seq_if;

    logic                        imem_req;
    logic [isa_pkg::WORD_W-1:0]  imem_addr;
    logic                        imem_ack;
    logic [isa_pkg::WORD_W-1:0]  imem_rdata;
    logic [isa_pkg::OPC_W-1:0]   alu_op;
    logic                        alu_mode;
    logic [isa_pkg::REG_AW-1:0]  rd_addr;
    logic [isa_pkg::REG_AW-1:0]  rs_addr;
    logic                        alu_valid;
    logic                        alu_done;
    logic                        flag_zero;
    logic                        flag_sign;
    logic [isa_pkg::WORD_W-1:0]  pc;
    logic                        trap;

    modport master (
        output imem_req, imem_addr, alu_op, alu_mode, rd_addr, rs_addr,
               alu_valid, pc, trap,
        input  imem_ack, imem_rdata, alu_done, flag_zero, flag_sign
    );

    modport slave (
        input  imem_req, imem_addr, alu_op, alu_mode, rd_addr, rs_addr,
               alu_valid, pc, trap,
        output imem_ack, imem_rdata, alu_done, flag_zero, flag_sign
    );

endinterface

// File: rtl/decode_seq_op_classify.sv
// Pure combinational opcode classifier: maps a 5-bit opcode onto its
// functional class and flags the four jump opcodes.
module op_classify
    import isa_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output opclass_e         opclass_o,
    output logic             is_jump_o
);

    always_comb begin
        opclass_o = CLS_ILLEGAL;
        is_jump_o = 1'b0;
        if (opcode_i <= OP_JMPZS) begin
            opclass_o = CLS_FLOW;
            is_jump_o = (opcode_i >= OP_JMP);
        end else if (opcode_i < OP_LOGIC_LO) begin
            opclass_o = CLS_STATUS;
        end else if (opcode_i < OP_SHIFT_LO) begin
            opclass_o = CLS_LOGIC;
        end else if (opcode_i < OP_ARITH_LO) begin
            opclass_o = CLS_SHIFT;
        end else if (opcode_i < OP_CMP_LO) begin
            opclass_o = CLS_ARITH;
        end else if (opcode_i < OP_ILLEGAL_LO) begin
            opclass_o = CLS_CMP;
        end
    end

endmodule

// File: rtl/decode_seq.sv
// Instruction fetch/decode sequencer: fetches words, resolves jumps and issues
// ALU operations. Define ILLEGAL_OPCODE_TRAP_EN to trap on opcodes 0x1C-0x1F.
module decode_seq
    import isa_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    decode_seq_if.master  bus
);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   pc_q, pc_d;
    logic [WORD_W-1:0]   instr_q, instr_d;
    logic [WORD_W-1:0]   pcNext;
    logic [OPC_W-1:0]    opcode;
    opclass_e            opClass;
    logic                isJump;
    logic                fetchReq;
    logic                aluValid;
    logic                unusedLowBits;

    assign opcode        = instr_q[19:15];
    assign pcNext        = pc_q + 20'd1;
    assign unusedLowBits = ^instr_q[5:0];

    op_classify u_op_classify (
        .opcode_i  (opcode),
        .opclass_o (opClass),
        .is_jump_o (isJump)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // imem_ack is only looked at in FETCH/TARGET and alu_done only in WAIT,
    // so stray pulses elsewhere fall through the default hold.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        fetchReq = 1'b0;
        aluValid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                fetchReq = 1'b1;
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    pc_d    = pcNext;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (opClass)
                    CLS_FLOW: begin
                        if (opcode == OP_TRAP) begin
                            state_d = ST_TRAP;
                        end else if (isJump) begin
                            state_d = ST_TARGET;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end
                    CLS_ILLEGAL: begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
                        state_d = ST_TRAP;
`else
                        state_d = ST_FETCH;
`endif
                    end
                    default: state_d = ST_ISSUE;
                endcase
            end
            ST_TARGET: begin
                fetchReq = 1'b1;
                if (bus.imem_ack) begin
                    pc_d    = jump_taken(opcode, bus.flag_zero, bus.flag_sign)
                              ? bus.imem_rdata : pcNext;
                    state_d = ST_FETCH;
                end
            end
            ST_ISSUE: begin
                aluValid = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.alu_done) begin
                    state_d = ST_FETCH;
                end
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ALU fields come straight from the latched word, which only changes in
    // FETCH, so they hold steady from ISSUE through WAIT.
    assign bus.imem_req  = fetchReq;
    assign bus.imem_addr = fetchReq ? pc_q : '0;
    assign bus.alu_valid = aluValid;
    assign bus.alu_op    = instr_q[19:15];
    assign bus.alu_mode  = instr_q[14];
    assign bus.rd_addr   = instr_q[13:10];
    assign bus.rs_addr   = instr_q[9:6];
    assign bus.pc        = pc_q;
    assign bus.trap      = (state_q == ST_TRAP);

endmodule

// File: tb/tb_decode_seq.sv
// Scoreboard bench for decode_seq: expected fetch addresses and ALU issues are
// queued with the stimulus and popped by independent monitors.
module tb_decode_seq;
    import isa_pkg::*;

    typedef struct packed {
        logic [4:0] op;
        logic       mode;
        logic [3:0] rd;
        logic [3:0] rs;
    } aluTxn_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_seq_if bus ();

    decode_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [19:0] mem [logic [19:0]];
    logic [19:0] fetchExp [$];
    aluTxn_t     aluExp [$];

    logic        ackQ = 1'b0;
    logic [19:0] rdataQ = '0;
    logic        doneQ = 1'b0;
    logic        ackEnable = 1'b1;
    logic        strayAck = 1'b0;
    logic        strayDone = 1'b0;
    logic        flagZero = 1'b0;
    logic        flagSign = 1'b0;
    int          doneDelay = 2;
    int          doneCnt = 0;
    int          checkCount = 0;
    int          errorCount = 0;

    logic        aluPending = 1'b0;
    aluTxn_t     lastIssue;
    aluTxn_t     seenIssue;
    aluTxn_t     expIssue;
    logic [19:0] expAddr;

    assign bus.imem_ack   = ackQ | strayAck;
    assign bus.imem_rdata = rdataQ;
    assign bus.alu_done   = doneQ | strayDone;
    assign bus.flag_zero  = flagZero;
    assign bus.flag_sign  = flagSign;

    // Zero-wait memory: every request cycle seen while enabled is answered.
    always @(negedge clk) begin
        ackQ   = bus.imem_req && ackEnable;
        rdataQ = mem.exists(bus.imem_addr) ? mem[bus.imem_addr] : 20'h00000;
    end

    // ALU model: completes doneDelay cycles after the issue pulse (0 = never).
    always @(negedge clk) begin
        doneQ = 1'b0;
        if (!rst_n) begin
            doneCnt = 0;
        end else if (bus.alu_valid) begin
            doneCnt = doneDelay;
        end else if (doneCnt > 0) begin
            doneCnt = doneCnt - 1;
            if (doneCnt == 0) doneQ = 1'b1;
        end
    end

    // Fetch monitor: each acknowledged request is one fetch transaction.
    always @(negedge clk) begin
        if (rst_n && bus.imem_req && ackEnable && fetchExp.size() != 0) begin
            expAddr = fetchExp.pop_front();
            checkCount++;
            if (bus.imem_addr !== expAddr) begin
                errorCount++;
                $display("[TB] FAIL fetchAddr actual=%05h required=%05h", bus.imem_addr, expAddr);
            end
        end
    end

    // ALU monitor: every issue pulse must be expected; fields must then hold
    // until the sequencer goes back to fetching.
    always @(negedge clk) begin
        if (!rst_n) begin
            aluPending = 1'b0;
        end else if (bus.alu_valid) begin
            seenIssue = {bus.alu_op, bus.alu_mode, bus.rd_addr, bus.rs_addr};
            checkCount++;
            if (aluExp.size() == 0) begin
                errorCount++;
                $display("[TB] FAIL aluIssue unexpected pulse actual=%h required=none", seenIssue);
            end else begin
                expIssue = aluExp.pop_front();
                if (seenIssue !== expIssue) begin
                    errorCount++;
                    $display("[TB] FAIL aluIssue actual=%h required=%h", seenIssue, expIssue);
                end
            end
            lastIssue  = seenIssue;
            aluPending = 1'b1;
        end else if (aluPending) begin
            if (bus.imem_req) begin
                aluPending = 1'b0;
            end else begin
                seenIssue = {bus.alu_op, bus.alu_mode, bus.rd_addr, bus.rs_addr};
                checkCount++;
                if (seenIssue !== lastIssue) begin
                    errorCount++;
                    $display("[TB] FAIL aluStable actual=%h required=%h", seenIssue, lastIssue);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] required);
        checkCount++;
        if (actual !== required) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input logic [19:0] addr, input logic [19:0] word);
        mem[addr] = word;
    endtask

    task automatic expectFetch(input logic [19:0] addr);
        fetchExp.push_back(addr);
    endtask

    task automatic expectAlu(input logic [4:0] op, input logic mode,
                             input logic [3:0] rd, input logic [3:0] rs);
        aluExp.push_back({op, mode, rd, rs});
    endtask

    // Reset always checks that every output collapses to zero at once.
    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("resetOutputs",
                    {bus.imem_req, bus.imem_addr, bus.alu_op, bus.alu_mode, bus.rd_addr,
                     bus.rs_addr, bus.alu_valid, bus.pc, bus.trap}, 64'h0);
        mem.delete();
        fetchExp.delete();
        aluExp.delete();
        ackEnable = 1'b1;
        strayAck  = 1'b0;
        strayDone = 1'b0;
        doneDelay = 2;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name, input int maxCycles);
        for (int i = 0; i < maxCycles && (fetchExp.size() != 0 || aluExp.size() != 0); i++)
            tick();
        checkOutput({name, "Pending"}, 64'(fetchExp.size() + aluExp.size()), 64'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // ALU issue; the first fetch holds at address 0 while imem stays silent.
        doReset();
        ackEnable = 1'b0;
        applyStimulus(20'h00000, 20'h8D180);   // ADD  full rd=4 rs=6
        applyStimulus(20'h00001, 20'h45180);   // op 0x08 full rd=4 rs=6
        applyStimulus(20'h00002, 20'h08000);   // NOP
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("fetchHold", {bus.imem_req, bus.imem_addr, bus.pc}, {1'b1, 20'h0, 20'h0});
        end
        expectFetch(20'h00000);
        expectAlu(5'h11, 1'b1, 4'd4, 4'd6);
        expectFetch(20'h00001);
        expectAlu(5'h08, 1'b1, 4'd4, 4'd6);
        expectFetch(20'h00002);
        ackEnable = 1'b1;
        drain("aluProgram", 60);

        // JMPZ taken and not taken.
        flagZero = 1'b1; flagSign = 1'b0;
        doReset();
        applyStimulus(20'h00000, 20'h18000);
        applyStimulus(20'h00001, 20'h00100);
        expectFetch(20'h00000); expectFetch(20'h00001); expectFetch(20'h00100);
        drain("jmpzTaken", 40);

        flagZero = 1'b0;
        doReset();
        applyStimulus(20'h00000, 20'h18000);
        applyStimulus(20'h00001, 20'h00100);
        expectFetch(20'h00000); expectFetch(20'h00001); expectFetch(20'h00002);
        drain("jmpzNotTaken", 40);

        // JMPZS needs both flags.
        flagZero = 1'b1; flagSign = 1'b0;
        doReset();
        applyStimulus(20'h00000, 20'h28000);
        applyStimulus(20'h00001, 20'h00100);
        expectFetch(20'h00000); expectFetch(20'h00001); expectFetch(20'h00002);
        drain("jmpzsNotTaken", 40);

        flagSign = 1'b1;
        doReset();
        applyStimulus(20'h00000, 20'h28000);
        applyStimulus(20'h00001, 20'h00100);
        expectFetch(20'h00000); expectFetch(20'h00001); expectFetch(20'h00100);
        drain("jmpzsTaken", 40);
        flagZero = 1'b0; flagSign = 1'b0;

        // pc wraps from 0xFFFFF to 0.
        doReset();
        applyStimulus(20'h00000, 20'h10000);
        applyStimulus(20'h00001, 20'hFFFFF);
        applyStimulus(20'hFFFFF, 20'h08000);
        expectFetch(20'h00000); expectFetch(20'h00001);
        expectFetch(20'hFFFFF); expectFetch(20'h00000);
        drain("pcWrap", 40);

        // TRAP is sticky and silences the fetch port.
        doReset();
        applyStimulus(20'h00000, 20'h00000);
        expectFetch(20'h00000);
        drain("trapFetch", 20);
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            checkOutput("trapHold", {bus.trap, bus.imem_req, bus.alu_valid}, 3'b100);
            tick();
        end

        // Illegal opcode 0x1D.
        doReset();
        applyStimulus(20'h00000, 20'hE8000);
        applyStimulus(20'h00001, 20'h08000);
        expectFetch(20'h00000);
`ifdef ILLEGAL_OPCODE_TRAP_EN
        drain("illegalFetch", 20);
        tick();
        tick();
        checkOutput("illegalTrap", {bus.trap, bus.imem_req}, 2'b10);
`else
        expectFetch(20'h00001);
        drain("illegalFetch", 20);
        checkOutput("illegalNoTrap", bus.trap, 1'b0);
`endif

        // Reset while parked in WAIT.
        doReset();
        doneDelay = 0;
        applyStimulus(20'h00000, 20'h8D180);
        expectFetch(20'h00000);
        expectAlu(5'h11, 1'b1, 4'd4, 4'd6);
        drain("waitIssue", 20);
        tick(); tick(); tick();
        checkOutput("waitParked", {bus.imem_req, bus.alu_valid, bus.alu_op}, {1'b0, 1'b0, 5'h11});
        doReset();
        applyStimulus(20'h00000, 20'h08000);
        expectFetch(20'h00000);
        drain("afterWaitReset", 20);

        // Stray ack/done in DECODE and done in ISSUE must be ignored.
        doReset();
        doneDelay = 0;
        applyStimulus(20'h00000, 20'h8D180);
        applyStimulus(20'h00001, 20'h08000);
        expectFetch(20'h00000);
        expectAlu(5'h11, 1'b1, 4'd4, 4'd6);
        for (int i = 0; i < 10 && !bus.imem_req; i++) tick();
        checkOutput("strayFetchSeen", bus.imem_req, 1'b1);
        tick();
        strayAck = 1'b1; strayDone = 1'b1;
        tick();
        checkOutput("strayIssue", {bus.alu_valid, bus.pc}, {1'b1, 20'h00001});
        strayAck = 1'b0;
        tick();
        strayDone = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("strayStillWaiting", {bus.imem_req, bus.alu_valid, bus.trap, bus.pc},
                        {3'b000, 20'h00001});
            tick();
        end
        expectFetch(20'h00001);
        strayDone = 1'b1;
        tick();
        strayDone = 1'b0;
        drain("strayResume", 20);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
